// File: rtl/packet_xor_recover.sv
// packet_xor_recover: XOR-accumulates k_num packets to rebuild one erased packet; PACKET_XOR_RECOVER_CHECK_EN adds out_zero.
// Latency: out_valid the cycle after the last accepted beat; backpressure: in_ready only in ACCUM, out_packet held until out_ready.
module packet_xor_recover #(
  parameter int K_MAX         = 128,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int CNT_W         = $clog2(K_MAX + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     k_num,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [0:W-1][PACKET_LENGTH-1:0]      in_packet,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [0:W-1][PACKET_LENGTH-1:0]      out_packet,
  output logic                                 busy,
`ifdef PACKET_XOR_RECOVER_CHECK_EN
  output logic                                 out_zero,
`endif
  output logic                                 err
);

  localparam logic [CNT_W-1:0] K_MAX_C = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic [CNT_W-1:0]                 remain;
  logic [0:W-1][PACKET_LENGTH-1:0]  acc;
  logic                             err_q;
  logic                             k_ok;
  logic                             start_ok;
  logic                             start_bad;
  logic                             in_fire;

  assign k_ok      = (k_num != '0) && (k_num <= K_MAX_C);
  assign start_ok  = (state == IDLE) && start && k_ok;
  assign start_bad = (state == IDLE) && start && !k_ok;
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs decode only the state register, so no in_* -> out_* path.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (remain == ONE_C)) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      remain <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        acc    <= '0;
        remain <= k_num;
      end else if (in_fire) begin
        for (int w = 0; w < W; w++) begin
          acc[w] <= acc[w] ^ in_packet[w];
        end
        remain <= remain - ONE_C;
      end
    end
  end

  assign out_packet = acc;
  assign err        = err_q;

`ifdef PACKET_XOR_RECOVER_CHECK_EN
  assign out_zero = out_valid && (acc == '0);
`endif

endmodule

// File: tb/tb_packet_xor_recover.sv
// Randomized bench for packet_xor_recover against a queue-based XOR reference model.
module tb_packet_xor_recover;

  localparam int K_MAX = 128;
  localparam int W     = 4;
  localparam int PL    = 2;
  localparam int CNT_W = $clog2(K_MAX + 1);

  typedef logic [0:W-1][PL-1:0] pkt_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] k_num = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  pkt_t             in_packet = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  pkt_t             out_packet;
  logic             busy;
  logic             err;
`ifdef PACKET_XOR_RECOVER_CHECK_EN
  logic             out_zero;
`endif

  int   errors = 0;
  int   checks = 0;
  pkt_t pkt_src [0:K_MAX-1];
  pkt_t got [$];

  packet_xor_recover #(
    .K_MAX(K_MAX), .W(W), .PACKET_LENGTH(PL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_num(k_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
    .busy(busy),
`ifdef PACKET_XOR_RECOVER_CHECK_EN
    .out_zero(out_zero),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input int a, input int b, input int c, input int d);
    pkt_t p;
    p[0] = PL'(a); p[1] = PL'(b); p[2] = PL'(c); p[3] = PL'(d);
    return p;
  endfunction

  // Erased packet = word-wise XOR of everything that was accepted.
  function automatic pkt_t xor_model(input pkt_t q[$]);
    pkt_t r = '0;
    foreach (q[i]) begin
      for (int w = 0; w < W; w++) r[w] = r[w] ^ q[i][w];
    end
    return r;
  endfunction

  task automatic run_job(input int k, input bit gapped, input int hold, input bit poke,
                         input string tag);
    int   beat = 0;
    int   cyc  = 0;
    bit   tog  = 1'b1;
    pkt_t exp_pkt;
    got.delete();
    start = 1'b1;
    k_num = CNT_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_start"}, int'(busy), 1);
    check({tag, ".in_ready_start"}, int'(in_ready), 1);
    while (beat < k && cyc < 4 * K_MAX + 16) begin
      in_valid  = gapped ? tog : 1'b1;
      tog       = ~tog;
      in_packet = pkt_src[beat];
      if (poke && cyc == 0) begin
        start = 1'b1;
        k_num = '0;
      end
      if (in_valid && in_ready) begin
        got.push_back(pkt_src[beat]);
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 1) begin
        start = 1'b0;
        check({tag, ".err_ignored_start"}, int'(err), 0);
        check({tag, ".busy_ignored_start"}, int'(busy), 1);
      end
    end
    in_valid = 1'b0;
    check({tag, ".beats"}, beat, k);
    if (!gapped) check({tag, ".latency"}, cyc, k);
    check({tag, ".out_valid"}, int'(out_valid), 1);
    check({tag, ".in_ready_drop"}, int'(in_ready), 0);
    exp_pkt = xor_model(got);
    check({tag, ".out_packet"}, int'(out_packet), int'(exp_pkt));
`ifdef PACKET_XOR_RECOVER_CHECK_EN
    check({tag, ".out_zero"}, int'(out_zero), int'(exp_pkt == '0));
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_packet = pkt_t'($urandom);
      @(posedge clk); #1;
      check({tag, ".hold_packet"}, int'(out_packet), int'(exp_pkt));
      check({tag, ".hold_valid"}, int'(out_valid), 1);
      check({tag, ".hold_busy"}, int'(busy), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_done"}, int'(out_valid), 0);
    check({tag, ".busy_done"}, int'(busy), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".in_ready"}, int'(in_ready), 0);
    check({tag, ".out_valid"}, int'(out_valid), 0);
    check({tag, ".out_packet"}, int'(out_packet), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".err"}, int'(err), 0);
`ifdef PACKET_XOR_RECOVER_CHECK_EN
    check({tag, ".out_zero"}, int'(out_zero), 0);
`endif
  endtask

  task automatic bad_start(input int k, input string tag);
    start = 1'b1;
    k_num = CNT_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".err_pulse"}, int'(err), 1);
    check({tag, ".busy"}, int'(busy), 0);
    @(posedge clk); #1;
    check({tag, ".err_clear"}, int'(err), 0);
    check({tag, ".busy_after"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Parity-check job: three packets that XOR to zero.
    pkt_src[0] = mk(1, 2, 3, 0);
    pkt_src[1] = mk(2, 2, 1, 1);
    pkt_src[2] = mk(3, 0, 2, 1);
    run_job(3, 1'b0, 0, 1'b0, "zero3");
    check("zero3.const", int'(xor_model(got)), int'(mk(0, 0, 0, 0)));

    // Recovery case with a 5-cycle output stall.
    pkt_src[0] = mk(1, 3, 0, 2);
    pkt_src[1] = mk(2, 3, 1, 1);
    run_job(2, 1'b0, 5, 1'b0, "recov2");
    check("recov2.const", int'(xor_model(got)), int'(mk(3, 0, 1, 3)));

    for (int i = 0; i < 4; i++) pkt_src[i] = pkt_t'($urandom);
    run_job(4, 1'b1, 2, 1'b0, "gapped4");

    bad_start(0, "k0");
    bad_start(K_MAX + 1, "kmax1");

    for (int i = 0; i < 3; i++) pkt_src[i] = pkt_t'($urandom);
    run_job(3, 1'b0, 1, 1'b1, "poke");

    // Reset in the middle of a 5-beat job; the partial result must vanish.
    start = 1'b1;
    k_num = CNT_W'(5);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      in_packet = pkt_t'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    reset_checks("midreset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset.no_emit", int'(out_valid), 0);
    pkt_src[0] = mk(3, 3, 3, 3);
    run_job(1, 1'b0, 0, 1'b0, "k1");
    check("k1.const", int'(xor_model(got)), int'(mk(3, 3, 3, 3)));

    for (int i = 0; i < K_MAX; i++) pkt_src[i] = pkt_t'($urandom);
    run_job(K_MAX, 1'b0, 0, 1'b0, "kmax");

    for (int j = 0; j < 10; j++) begin
      int k = int'($urandom_range(1, 16));
      for (int i = 0; i < k; i++) pkt_src[i] = pkt_t'($urandom);
      run_job(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
